bin2bcd_display: RTL and testbench

- Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment multiplexer.
- Takes a 16-bit unsigned binary value from the CPU/debug side and converts it by shift-and-add-3 (double dabble).
- Presents the result as four packed BCD nibbles on the multiplexer's 16-bit data input.
- The display therefore shows decimal rather than hex; the output holds steady between conversions so the display never flickers mid-update.

---
 rtl/bin2bcd_display.sv | 130 +++++++++++++
 tb/tb_bin2bcd_display.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_display.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (double dabble) that feeds
// the seven-segment multiplexer; results are held steady between conversions.
module bin2bcd_display #(
   parameter int OVF_MODE = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [15:0] bcd
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic [15:0] shift_r;
   logic [19:0] scratch_r;
   logic [4:0]  step_r;
   logic        busy_r;
   logic        done_r;
   logic        ovf_r;
   logic [15:0] bcd_r;
   logic [19:0] adj_s;
   logic        over_s;

   function automatic logic [3:0] add3(input logic [3:0] d);
      if (d >= 4'd5) begin
         add3 = d + 4'd3;
      end else begin
         add3 = d;
      end
   endfunction

   // Digit correction before each shift, and the out-of-range test on the final scratch
   always_comb begin
      adj_s  = {add3(scratch_r[19:16]), add3(scratch_r[15:12]), add3(scratch_r[11:8]),
                add3(scratch_r[7:4]), add3(scratch_r[3:0])};
      over_s = (scratch_r[19:16] != 4'd0) || (scratch_r[15:0] > 16'h9999);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic: start is honoured only in IDLE, so it is ignored during LOAD
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = CONV;
            end else begin
               next_state_s = IDLE;
            end
         end
         CONV: begin
            if (step_r == 5'd15) begin
               next_state_s = LOAD;
            end else begin
               next_state_s = CONV;
            end
         end
         LOAD:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_r   <= 16'h0000;
         scratch_r <= 20'h00000;
         step_r    <= 5'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         ovf_r     <= 1'b0;
         bcd_r     <= 16'h0000;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  shift_r   <= bin;
                  scratch_r <= 20'h00000;
                  step_r    <= 5'd0;
                  busy_r    <= 1'b1;
               end
            end
            CONV: begin
               {scratch_r, shift_r} <= {adj_s[18:0], shift_r, 1'b0};
               step_r               <= step_r + 5'd1;
            end
            LOAD: begin
               // Wrap mode keeps the low four decimal digits (value mod 10000)
               if (over_s) begin
                  ovf_r <= 1'b1;
                  bcd_r <= (OVF_MODE == 0) ? 16'h9999 : scratch_r[15:0];
               end else begin
                  ovf_r <= 1'b0;
                  bcd_r <= scratch_r[15:0];
               end
               done_r <= 1'b1;
               busy_r <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign ovf  = ovf_r;
   assign bcd  = bcd_r;

endmodule

// File: tb/tb_bin2bcd_display.sv
// Self-checking bench: a saturating and a wrapping instance share stimulus and are
// compared every cycle against an arithmetic reference model.
module tb_bin2bcd_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] bin = 16'h0000;
   logic        busy0, done0, ovf0, busy1, done1, ovf1;
   logic [15:0] bcd0, bcd1;

   int n_tests = 0;
   int n_fail  = 0;
   bit checking = 1'b0;

   bin2bcd_display #(.OVF_MODE(0)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy0), .done(done0), .ovf(ovf0), .bcd(bcd0));

   bin2bcd_display #(.OVF_MODE(1)) u_wrap (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy1), .done(done1), .ovf(ovf1), .bcd(bcd1));

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      int r;
      r = (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
      return r[15:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a conversion takes 17 edges after the accepting edge
   logic        m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
   logic [15:0] m_bcd0 = 16'h0000, m_bcd1 = 16'h0000;
   int          m_val = 0, m_cnt = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_ovf <= 1'b0;
         m_bcd0 <= 16'h0000; m_bcd1 <= 16'h0000; m_cnt <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy && start) begin
            m_busy <= 1'b1; m_val <= int'(bin); m_cnt <= 0;
         end else if (m_busy) begin
            if (m_cnt == 16) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_ovf  <= (m_val > 9999);
               m_bcd0 <= (m_val > 9999) ? 16'h9999 : to_bcd(m_val);
               m_bcd1 <= to_bcd(m_val % 10000);
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (checking) begin
         chk("busy_sat", {31'd0, busy0}, {31'd0, m_busy});
         chk("done_sat", {31'd0, done0}, {31'd0, m_done});
         chk("ovf_sat",  {31'd0, ovf0},  {31'd0, m_ovf});
         chk("bcd_sat",  {16'd0, bcd0},  {16'd0, m_bcd0});
         chk("busy_wrap", {31'd0, busy1}, {31'd0, m_busy});
         chk("done_wrap", {31'd0, done1}, {31'd0, m_done});
         chk("ovf_wrap",  {31'd0, ovf1},  {31'd0, m_ovf});
         chk("bcd_wrap",  {16'd0, bcd1},  {16'd0, m_bcd1});
      end
   end

   task automatic convert(input logic [15:0] v, output int busy_cycles);
      int dones;
      busy_cycles = 0;
      dones = 0;
      @(negedge clk);
      start = 1'b1;
      bin   = v;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy0) busy_cycles++;
         if (done0) begin
            dones++;
            break;
         end
      end
      chk("done_seen", dones, 1);
   endtask

   initial begin
      int bc;
      int dcnt;
      int t_done[$];
      repeat (3) @(negedge clk);
      checking = 1'b1;
      chk("reset_bcd", {16'd0, bcd0}, 32'h0000);
      chk("reset_busy", {31'd0, busy0}, 32'd0);
      rst_n = 1'b1;

      convert(16'd1234, bc);
      chk("busy_len", bc, 17);
      chk("pin_1234", {16'd0, bcd0}, 32'h1234);
      chk("pin_1234_ovf", {31'd0, ovf0}, 32'd0);

      convert(16'd0, bc);
      chk("pin_0", {16'd0, bcd0}, 32'h0000);
      convert(16'd9999, bc);
      chk("pin_9999", {16'd0, bcd0}, 32'h9999);
      chk("pin_9999_ovf", {31'd0, ovf0}, 32'd0);

      convert(16'd10000, bc);
      chk("pin_10000_sat", {16'd0, bcd0}, 32'h9999);
      chk("pin_10000_wrap", {16'd0, bcd1}, 32'h0000);
      chk("pin_10000_ovf", {31'd0, ovf1}, 32'd1);
      convert(16'd65535, bc);
      chk("pin_65535_sat", {16'd0, bcd0}, 32'h9999);
      chk("pin_65535_wrap", {16'd0, bcd1}, 32'h5535);

      // start pulsed mid-conversion is dropped
      @(negedge clk); start = 1'b1; bin = 16'd42;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; bin = 16'd777;
      @(negedge clk); start = 1'b0; bin = 16'd0;
      dcnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done0) dcnt++;
      end
      chk("ignored_start_dones", dcnt, 1);
      chk("pin_42", {16'd0, bcd0}, 32'h0042);
      convert(16'd777, bc);
      chk("pin_777", {16'd0, bcd0}, 32'h0777);

      // reset mid-conversion discards the partial result
      convert(16'd1234, bc);
      @(negedge clk); start = 1'b1; bin = 16'd4321;
      @(negedge clk); start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      chk("midreset_bcd", {16'd0, bcd0}, 32'h0000);
      chk("midreset_busy", {31'd0, busy0}, 32'd0);
      dcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done0) dcnt++;
      end
      chk("midreset_no_done", dcnt, 0);
      convert(16'd4321, bc);
      chk("pin_4321", {16'd0, bcd0}, 32'h4321);

      // start held high re-triggers every 18 cycles
      start = 1'b1;
      for (int i = 0; i < 70; i++) begin
         bin = 16'(5 + (i % 3));
         @(negedge clk);
         if (done0) t_done.push_back(i);
      end
      start = 1'b0;
      repeat (20) @(negedge clk);
      chk("b2b_count", (t_done.size() >= 3) ? 1 : 0, 1);
      if (t_done.size() >= 3) begin
         chk("b2b_gap1", t_done[1] - t_done[0], 18);
         chk("b2b_gap2", t_done[2] - t_done[1], 18);
      end

      // randomized conversions with stray start pulses while busy
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         start = 1'b1;
         bin = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(10000, 65535))
                                           : 16'($urandom_range(0, 9999));
         @(negedge clk);
         start = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            bin = 16'($urandom);
         end
         start = 1'b0;
         repeat (2) @(negedge clk);
      end

      @(negedge clk);
      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
